// File: rtl/vga_bounce_box_module.sv
// rtl/vga_bounce_box_module.sv - bouncing box over colour bars with a red border, 1-clk registered pixel path
module vga_bounce_box_module #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int BOX      = 64,
  parameter int STEP     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic [10:0] column_addr_sig,
  input  logic [10:0] row_addr_sig,
  input  logic        hsync_sig,
  input  logic        vsync_sig,
  output logic [4:0]  red_sig,
  output logic [5:0]  green_sig,
  output logic [4:0]  blue_sig,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam logic [0:0] RIGHT = 1'b0;
  localparam logic [0:0] LEFT  = 1'b1;
  localparam logic [0:0] DOWN  = 1'b0;
  localparam logic [0:0] UP    = 1'b1;

  localparam logic [11:0] X_MAX  = 12'(H_ACTIVE - BOX);
  localparam logic [11:0] Y_MAX  = 12'(V_ACTIVE - BOX);
  localparam logic [11:0] STEP_W = 12'(STEP);
  localparam logic [11:0] BOX_W  = 12'(BOX);
  localparam logic [11:0] H_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] V_LAST = 12'(V_ACTIVE - 1);

  logic [10:0] box_x, box_y;
  logic [0:0]  x_state, y_state;
  logic        vsync_q2;
  logic        frame_tick;

  // vsync_out doubles as the first history stage; both reset high so release never looks like an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      vsync_q2  <= 1'b1;
    end else begin
      hsync_out <= hsync_sig;
      vsync_out <= vsync_sig;
      vsync_q2  <= vsync_out;
    end
  end

  assign frame_tick = vsync_out & ~vsync_q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      box_x   <= '0;
      x_state <= RIGHT;
    end else if (frame_tick) begin
      if (x_state == RIGHT) begin
        if ({1'b0, box_x} + STEP_W >= X_MAX) begin
          box_x   <= X_MAX[10:0];
          x_state <= LEFT;
        end else begin
          box_x <= box_x + STEP_W[10:0];
        end
      end else begin
        if ({1'b0, box_x} <= STEP_W) begin
          box_x   <= '0;
          x_state <= RIGHT;
        end else begin
          box_x <= box_x - STEP_W[10:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      box_y   <= '0;
      y_state <= DOWN;
    end else if (frame_tick) begin
      if (y_state == DOWN) begin
        if ({1'b0, box_y} + STEP_W >= Y_MAX) begin
          box_y   <= Y_MAX[10:0];
          y_state <= UP;
        end else begin
          box_y <= box_y + STEP_W[10:0];
        end
      end else begin
        if ({1'b0, box_y} <= STEP_W) begin
          box_y   <= '0;
          y_state <= DOWN;
        end else begin
          box_y <= box_y - STEP_W[10:0];
        end
      end
    end
  end

  logic [11:0] col_w, row_w;
  logic        in_box, on_border;
  logic [2:0]  idx;
  logic [4:0]  red_n, blue_n;
  logic [5:0]  green_n;

  assign col_w = {1'b0, column_addr_sig};
  assign row_w = {1'b0, row_addr_sig};
  assign idx   = column_addr_sig[9:7];

  // 12-bit compares keep box_x+BOX from wrapping near the right edge
  assign in_box = (col_w >= {1'b0, box_x}) && (col_w < {1'b0, box_x} + BOX_W) &&
                  (row_w >= {1'b0, box_y}) && (row_w < {1'b0, box_y} + BOX_W);
  assign on_border = (col_w == 12'd0) || (col_w == H_LAST) ||
                     (row_w == 12'd0) || (row_w == V_LAST);

  always_comb begin
    red_n   = '0;
    green_n = '0;
    blue_n  = '0;
    if (ready) begin
      if (in_box) begin
        red_n   = 5'h1F;
        green_n = 6'h3F;
        blue_n  = 5'h1F;
      end else if (on_border) begin
        red_n = 5'h1F;
      end else begin
        red_n   = {5{idx[2]}};
        green_n = {6{idx[1]}};
        blue_n  = {5{idx[0]}};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red_sig   <= '0;
      green_sig <= '0;
      blue_sig  <= '0;
    end else begin
      red_sig   <= red_n;
      green_sig <= green_n;
      blue_sig  <= blue_n;
    end
  end

endmodule

// File: tb/tb_vga_bounce_box_module.sv
// tb/tb_vga_bounce_box_module.sv - self-checking bench for vga_bounce_box_module (STEP=2 and STEP=3 instances)
module tb_vga_bounce_box_module;

  localparam int H = 800;
  localparam int V = 600;
  localparam int B = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [10:0] col, row;
  logic        hsync_sig, vsync_sig;
  logic [4:0]  red_a, blue_a, red_b, blue_b;
  logic [5:0]  green_a, green_b;
  logic        hs_a, vs_a, hs_b, vs_b;

  int tests = 0;
  int fails = 0;
  int xa, ya, dxa, dya;
  int xb, yb, dxb, dyb;

  always #5 clk = ~clk;

  vga_bounce_box_module #(.H_ACTIVE(H), .V_ACTIVE(V), .BOX(B), .STEP(2)) dut_a (
    .clk(clk), .rst(rst), .ready(ready), .column_addr_sig(col), .row_addr_sig(row),
    .hsync_sig(hsync_sig), .vsync_sig(vsync_sig),
    .red_sig(red_a), .green_sig(green_a), .blue_sig(blue_a),
    .hsync_out(hs_a), .vsync_out(vs_a));

  vga_bounce_box_module #(.H_ACTIVE(H), .V_ACTIVE(V), .BOX(B), .STEP(3)) dut_b (
    .clk(clk), .rst(rst), .ready(ready), .column_addr_sig(col), .row_addr_sig(row),
    .hsync_sig(hsync_sig), .vsync_sig(vsync_sig),
    .red_sig(red_b), .green_sig(green_b), .blue_sig(blue_b),
    .hsync_out(hs_b), .vsync_out(vs_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_rgb(bit rdy, int c, int r, int bx, int by);
    int idx;
    if (!rdy) return 16'h0;
    if (c >= bx && c <= bx + B - 1 && r >= by && r <= by + B - 1) return 16'hFFFF;
    if (c == 0 || c == H - 1 || r == 0 || r == V - 1) return 16'hF800;
    idx = (c / 128) % 8;
    return {((idx & 4) != 0) ? 5'h1F : 5'h00,
            ((idx & 2) != 0) ? 6'h3F : 6'h00,
            ((idx & 1) != 0) ? 5'h1F : 5'h00};
  endfunction

  task automatic bounce(inout int x, inout int d, input int lim, input int st);
    if (d > 0) begin
      if (x + st >= lim) begin x = lim; d = -1; end
      else x = x + st;
    end else begin
      if (x <= st) begin x = 0; d = 1; end
      else x = x - st;
    end
  endtask

  task automatic model_reset();
    xa = 0; ya = 0; dxa = 1; dya = 1;
    xb = 0; yb = 0; dxb = 1; dyb = 1;
  endtask

  task automatic pix(input bit rdy, input int c, input int r);
    @(negedge clk);
    ready = rdy; col = 11'(c); row = 11'(r);
    @(posedge clk); #1;
    chk($sformatf("rgb_s2(%0d,%0d,%0d)", rdy, c, r), {16'h0, red_a, green_a, blue_a}, {16'h0, exp_rgb(rdy, c, r, xa, ya)});
    chk($sformatf("rgb_s3(%0d,%0d,%0d)", rdy, c, r), {16'h0, red_b, green_b, blue_b}, {16'h0, exp_rgb(rdy, c, r, xb, yb)});
  endtask

  task automatic vpulse();
    @(negedge clk); vsync_sig = 1'b0;
    @(posedge clk); #1;
    chk("vsync_out_low", {31'h0, vs_a & vs_b}, 32'h0);
    @(negedge clk); vsync_sig = 1'b1;
    repeat (3) @(posedge clk);
    bounce(xa, dxa, H - B, 2); bounce(ya, dya, V - B, 2);
    bounce(xb, dxb, H - B, 3); bounce(yb, dyb, V - B, 3);
  endtask

  function automatic int clampc(int v, int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic rand_checks();
    pix(($urandom_range(0, 7) != 0), $urandom_range(0, H - 1), $urandom_range(0, V - 1));
    pix(1'b1, clampc(xa + $urandom_range(0, B + 1) - 1, H - 1), clampc(ya + $urandom_range(0, B + 1) - 1, V - 1));
    pix(1'b1, clampc(xb + B - 1 + $urandom_range(0, 1), H - 1), clampc(yb + B - 1 + $urandom_range(0, 1), V - 1));
  endtask

  initial begin
    rst = 1'b1; ready = 1'b1; col = 11'd10; row = 11'd10;
    hsync_sig = 1'b0; vsync_sig = 1'b1;
    model_reset();
    repeat (3) @(posedge clk); #1;
    chk("rst_rgb_a", {16'h0, red_a, green_a, blue_a}, 32'h0);
    chk("rst_rgb_b", {16'h0, red_b, green_b, blue_b}, 32'h0);
    chk("rst_hsync", {31'h0, hs_a}, 32'h1);
    chk("rst_vsync", {31'h0, vs_a}, 32'h1);
    @(negedge clk); rst = 1'b0; hsync_sig = 1'b1;

    pix(1'b1, 10, 10);
    pix(1'b1, 64, 10);
    pix(1'b1, 300, 0);

    vpulse();
    pix(1'b1, 2, 2);
    pix(1'b1, 1, 2);
    pix(1'b1, 65, 2);
    pix(1'b1, 66, 2);

    for (int i = 1; i < 368; i++) begin
      vpulse();
      rand_checks();
    end
    pix(1'b1, 736, ya);
    pix(1'b1, 735, ya);
    vpulse();
    pix(1'b1, 734, ya);
    pix(1'b1, 797, ya);
    pix(1'b1, 798, ya);

    pix(1'b0, xa + 5, ya + 5);

    @(negedge clk); hsync_sig = 1'b0;
    #1 chk("hsync_delay_old", {31'h0, hs_a}, 32'h1);
    @(posedge clk); #1;
    chk("hsync_follow_low", {31'h0, hs_a & hs_b}, 32'h0);
    @(negedge clk); hsync_sig = 1'b1;
    @(posedge clk); #1;
    chk("hsync_follow_high", {31'h0, hs_a | hs_b}, 32'h1);

    for (int i = 0; i < 50; i++) vpulse();
    @(negedge clk); hsync_sig = 1'b0; ready = 1'b1; col = 11'(xa + 1); row = 11'(ya + 1);
    @(posedge clk); #1;
    chk("pre_rst_rgb", {16'h0, red_a, green_a, blue_a}, 32'hFFFF);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_rgb_a", {16'h0, red_a, green_a, blue_a}, 32'h0);
    chk("async_rst_rgb_b", {16'h0, red_b, green_b, blue_b}, 32'h0);
    chk("async_rst_hsync", {31'h0, hs_a & hs_b}, 32'h1);
    @(negedge clk); rst = 1'b0; hsync_sig = 1'b1;
    model_reset();
    pix(1'b1, 10, 10);
    pix(1'b1, 64, 10);
    vpulse();
    pix(1'b1, 2, 2);
    pix(1'b1, 1, 2);

    for (int i = 0; i < 260; i++) begin
      vpulse();
      rand_checks();
      if (xb >= 730) begin
        pix(1'b1, 736, yb);
        pix(1'b1, 799, yb);
      end
    end
    pix(1'b1, 799, 300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
